// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: host-side read port of the UART receiver FIFO.
// master = receiver (drives head/status), slave = host (pops, clears overflow).
interface uart_rx_fifo_if #(parameter int FIFO_DEPTH = 8);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [7:0] rdData;
    logic rdParityErr;
    logic rdFrameErr;
    logic rdBreak;
    logic rdValid;
    logic rdReady;
    logic [CW-1:0] fifoCount;
    logic overflow;
    logic clrOverflow;
    modport master (
        output rdData, rdParityErr, rdFrameErr, rdBreak, rdValid, fifoCount, overflow,
        input rdReady, clrOverflow
    );
    modport slave (
        input rdData, rdParityErr, rdFrameErr, rdBreak, rdValid, fifoCount, overflow,
        output rdReady, clrOverflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled majority-vote UART receiver feeding a show-ahead FIFO
// whose entries carry {break, frameErr, parityErr, data}.
module uart_rx_fifo #(
    parameter int DIV_WIDTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic rstN,
    input logic rx,
    input logic [1:0] dataBits,
    input logic hasParity,
    input logic [1:0] parityMode,
    input logic extraStopBit,
    input logic [DIV_WIDTH-1:0] baudDivisor,
    uart_rx_fifo_if.master rd
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int M = OVERSAMPLE / 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} stateT;
    stateT state;
    logic rxMeta, rxS, rxPrev;
    logic [1:0] dbL, pmL;
    logic hpL, esL;
    logic [DIV_WIDTH-1:0] baudL, divCnt;
    logic [SW-1:0] s;
    logic [2:0] votes, votesNext, bitCnt;
    logic [7:0] data;
    logic parBit, pushReq;
    logic [10:0] pushEntry;
    logic tick, sampleTick, resolve, bitVal, parOdd, parityErr, isBreak;
    assign tick = (state != IDLE) && (divCnt == baudL);
    assign sampleTick = tick && (s == SW'(M - 1) || s == SW'(M) || s == SW'(M + 1));
    assign resolve = tick && (s == SW'(OVERSAMPLE - 1));
    // the last vote may land on the resolving tick itself when OVERSAMPLE is 4
    assign votesNext = sampleTick ? {votes[1:0], rxS} : votes;
    assign bitVal = (votesNext[0] & votesNext[1]) | (votesNext[0] & votesNext[2]) | (votesNext[1] & votesNext[2]);
    assign parOdd = ^data ^ parBit;
    assign parityErr = hpL && (pmL == 2'b10 ? parOdd : pmL == 2'b01 ? !parOdd : pmL == 2'b11 ? !parBit : parBit);
    assign isBreak = (data == 8'd0) && !parBit;
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            rxMeta <= 1'b1;
            rxS <= 1'b1;
            rxPrev <= 1'b1;
            dbL <= '0;
            pmL <= '0;
            hpL <= 1'b0;
            esL <= 1'b0;
            baudL <= '0;
            divCnt <= '0;
            s <= '0;
            votes <= '0;
            bitCnt <= '0;
            data <= '0;
            parBit <= 1'b0;
            pushReq <= 1'b0;
            pushEntry <= '0;
        end else begin
            rxMeta <= rx;
            rxS <= rxMeta;
            rxPrev <= rxS;
            pushReq <= 1'b0;
            divCnt <= (state == IDLE || tick) ? '0 : divCnt + 1'b1;
            if (tick) begin
                s <= resolve ? '0 : s + 1'b1;
                votes <= votesNext;
            end
            case (state)
                IDLE: if (rxPrev && !rxS) begin
                    state <= START;
                    dbL <= dataBits;
                    hpL <= hasParity;
                    pmL <= parityMode;
                    esL <= extraStopBit;
                    baudL <= baudDivisor;
                    s <= '0;
                    bitCnt <= '0;
                    data <= '0;
                    parBit <= 1'b0;
                end
                START: if (resolve) state <= bitVal ? IDLE : DATA;
                DATA: if (resolve) begin
                    data[bitCnt] <= bitVal;
                    bitCnt <= bitCnt + 1'b1;
                    if (bitCnt == 3'(dbL) + 3'd4) state <= hpL ? PARITY : STOP1;
                end
                PARITY: if (resolve) begin
                    parBit <= bitVal;
                    state <= STOP1;
                end
                STOP1: if (resolve) begin
                    if (bitVal && esL) state <= STOP2;
                    else begin
                        pushReq <= 1'b1;
                        pushEntry <= {!bitVal && isBreak, !bitVal, parityErr, data};
                        state <= bitVal ? IDLE : WAIT_HIGH;
                    end
                end
                STOP2: if (resolve) begin
                    pushReq <= 1'b1;
                    pushEntry <= {1'b0, !bitVal, parityErr, data};
                    state <= bitVal ? IDLE : WAIT_HIGH;
                end
                default: if (rxS) state <= IDLE;
            endcase
        end
    end
    logic [10:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic full, pop, wr;
    logic [10:0] head;
    assign full = count == CW'(FIFO_DEPTH);
    assign pop = rd.rdReady && (count != '0);
    assign wr = pushReq && (!full || pop);
    assign head = (count != '0) ? mem[rdPtr] : '0;
    always_ff @(posedge clk) begin
        if (wr) mem[wrPtr] <= pushEntry;
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            rd.overflow <= 1'b0;
        end else begin
            wrPtr <= wrPtr + PW'(wr);
            rdPtr <= rdPtr + PW'(pop);
            count <= count + CW'(wr) - CW'(pop);
            rd.overflow <= (pushReq && full && !pop) ? 1'b1 : rd.clrOverflow ? 1'b0 : rd.overflow;
        end
    end
    assign rd.rdData = head[7:0];
    assign rd.rdParityErr = head[8];
    assign rd.rdFrameErr = head[9];
    assign rd.rdBreak = head[10];
    assign rd.rdValid = count != '0;
    assign rd.fifoCount = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames at 64 clk/bit; a scoreboard queue models the FIFO
// contents and occupancy, and each popped head is checked against it.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic rx = 1'b1;
    logic [1:0] dataBits = 2'd3;
    logic [1:0] parityMode = 2'b00;
    logic hasParity = 1'b0;
    logic extraStopBit = 1'b0;
    logic [15:0] baudDivisor = 16'd3;
    int checks = 0;
    int failures = 0;
    logic [10:0] sb[$];
    int mcount = 0;
    logic expOvf = 1'b0;
    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rd();
    uart_rx_fifo #(.DIV_WIDTH(16), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rstN), .rx(rx), .dataBits(dataBits), .hasParity(hasParity),
        .parityMode(parityMode), .extraStopBit(extraStopBit), .baudDivisor(baudDivisor),
        .rd(rd.master)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic bitTime(input logic v);
        rx = v;
        repeat (64) @(negedge clk);
    endtask
    function automatic logic expPar(input logic [7:0] d, input logic p, input logic [1:0] m);
        case (m)
            2'b10: return ^d ^ p;
            2'b01: return ~(^d ^ p);
            2'b11: return !p;
            default: return p;
        endcase
    endfunction
    task automatic expectFrame(input logic [10:0] e);
        if (mcount < DEPTH) begin
            sb.push_back(e);
            mcount++;
        end else expOvf = 1'b1;
    endtask
    task automatic sendFrame(input logic [7:0] d, input logic pbit, input logic st1, input logic st2);
        bitTime(1'b0);
        for (int i = 0; i < int'(dataBits) + 5; i++) bitTime(d[i]);
        if (hasParity) bitTime(pbit);
        bitTime(st1);
        if (extraStopBit) bitTime(st2);
        rx = 1'b1;
        repeat (32) @(negedge clk);
    endtask
    task automatic waitValid();
        for (int i = 0; i < 400 && !rd.rdValid; i++) @(negedge clk);
    endtask
    task automatic popCheck(input string tag);
        logic [10:0] e;
        waitValid();
        chk({tag, " valid"}, rd.rdValid, 1);
        e = sb.size() != 0 ? sb.pop_front() : 11'h7ff;
        chk({tag, " data"}, rd.rdData, e[7:0]);
        chk({tag, " parityErr"}, rd.rdParityErr, e[8]);
        chk({tag, " frameErr"}, rd.rdFrameErr, e[9]);
        chk({tag, " break"}, rd.rdBreak, e[10]);
        rd.rdReady = 1'b1;
        @(negedge clk);
        rd.rdReady = 1'b0;
        if (mcount > 0) mcount--;
    endtask
    initial begin
        rd.rdReady = 1'b0;
        rd.clrOverflow = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset valid", rd.rdValid, 0);
        chk("reset count", rd.fifoCount, 0);
        chk("reset overflow", rd.overflow, 0);
        chk("reset data", rd.rdData, 0);
        rstN = 1'b1;
        repeat (10) @(negedge clk);
        // 8N1 0xA5
        expectFrame({3'b000, 8'hA5});
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b1);
        waitValid();
        chk("t1 count", rd.fifoCount, mcount);
        popCheck("t1");
        // 7E1 0x41 with wrong then correct parity
        dataBits = 2'd2;
        hasParity = 1'b1;
        parityMode = 2'b10;
        expectFrame({2'b00, expPar(8'h41, 1'b1, 2'b10), 8'h41});
        sendFrame(8'h41, 1'b1, 1'b1, 1'b1);
        popCheck("t2 bad parity");
        expectFrame({2'b00, expPar(8'h41, 1'b0, 2'b10), 8'h41});
        sendFrame(8'h41, 1'b0, 1'b1, 1'b1);
        popCheck("t2 good parity");
        // glitch shorter than half a bit
        dataBits = 2'd3;
        hasParity = 1'b0;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("t3 glitch count", rd.fifoCount, 0);
        expectFrame({3'b000, 8'h3C});
        sendFrame(8'h3C, 1'b0, 1'b1, 1'b1);
        popCheck("t3");
        // line held low for 12 bit times
        rx = 1'b0;
        repeat (12 * 64) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        expectFrame({3'b110, 8'h00});
        chk("t4 break count", rd.fifoCount, mcount);
        popCheck("t4 break");
        expectFrame({3'b000, 8'h55});
        sendFrame(8'h55, 1'b0, 1'b1, 1'b1);
        popCheck("t4 after");
        // overflow with reads stalled
        for (int i = 1; i <= 5; i++) begin
            expectFrame({3'b000, 8'(i)});
            sendFrame(8'(i), 1'b0, 1'b1, 1'b1);
        end
        chk("t5 count", rd.fifoCount, mcount);
        chk("t5 overflow", rd.overflow, expOvf);
        for (int i = 1; i <= 4; i++) popCheck($sformatf("t5 pop%0d", i));
        chk("t5 empty", rd.rdValid, 0);
        rd.clrOverflow = 1'b1;
        @(negedge clk);
        rd.clrOverflow = 1'b0;
        expOvf = 1'b0;
        chk("t5 cleared", rd.overflow, expOvf);
        // async reset mid-frame with an entry waiting
        expectFrame({3'b000, 8'h12});
        sendFrame(8'h12, 1'b0, 1'b1, 1'b1);
        waitValid();
        chk("t6 pre count", rd.fifoCount, mcount);
        bitTime(1'b0);
        bitTime(1'b1);
        bitTime(1'b0);
        repeat (20) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("t6 rst valid", rd.rdValid, 0);
        chk("t6 rst count", rd.fifoCount, 0);
        chk("t6 rst data", rd.rdData, 0);
        chk("t6 rst overflow", rd.overflow, 0);
        sb.delete();
        mcount = 0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rstN = 1'b1;
        repeat (10) @(negedge clk);
        // 8O2 with bad second stop bit
        dataBits = 2'd3;
        hasParity = 1'b1;
        parityMode = 2'b01;
        extraStopBit = 1'b1;
        expectFrame({2'b01, expPar(8'h7E, 1'b1, 2'b01), 8'h7E});
        sendFrame(8'h7E, 1'b1, 1'b1, 1'b0);
        popCheck("t6 8O2");
        chk("end count", rd.fifoCount, mcount);
        chk("end overflow", rd.overflow, expOvf);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
